// File: rtl/mm_result_collector.sv
// mm_result_collector: buffers the matrix-multiply engine's result stream,
// tags each element with its row/column and drains the matrix to a consumer
// over a valid/ready handshake once the engine drops mm_busy.
// Illegal-dimension results are reported as a single mat_done+mat_illegal pulse.
// Optional feature macro: MM_COLLECT_ROWSUM_EN (per-row signed sum outputs).
module mm_result_collector #(
    parameter int DATA_W = 20,
    parameter int DEPTH  = 16,
    parameter int IDX_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] mm_data,
    input  logic              mm_valid,
    input  logic              mm_legal,
    input  logic              mm_change_row,
    input  logic              mm_busy,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [IDX_W-1:0]  rd_row,
    output logic [IDX_W-1:0]  rd_col,
    output logic              rd_last,
    output logic              mat_done,
    output logic              mat_illegal,
    output logic              overflow
`ifdef MM_COLLECT_ROWSUM_EN
   ,output logic signed [DATA_W+IDX_W-1:0] row_sum,
    output logic                           row_sum_valid
`endif
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_DRAIN,
        S_ERROR
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [IDX_W-1:0]  mem_row  [DEPTH];
    logic [IDX_W-1:0]  mem_col  [DEPTH];

    // Pointers carry one extra bit so "full" (DEPTH stored) is distinct from empty.
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [IDX_W-1:0] row_cnt;
    logic [IDX_W-1:0] col_cnt;
    logic             busy_q;

    logic busy_fall;
    logic empty;
    logic full;
    logic accept_state;
    logic bad_elem;
    logic write_en;
    logic drop;
    logic clear_buf;
    logic rd_fire;

    assign busy_fall    = busy_q & ~mm_busy;
    assign empty        = (rd_ptr == wr_ptr);
    assign full         = (wr_ptr == PTR_W'(DEPTH));
    assign accept_state = (state == S_IDLE) || (state == S_COLLECT);
    assign bad_elem     = accept_state & mm_valid & ~mm_legal;
    assign write_en     = accept_state & mm_valid & mm_legal & ~full;
    assign drop         = (accept_state & mm_valid & mm_legal & full)
                        | ((state == S_DRAIN) & mm_valid);
    // DRAIN with an empty buffer is the mat_done cycle; pointers reset at its end.
    assign clear_buf    = bad_elem | (state == S_ERROR) | ((state == S_DRAIN) & empty);
    assign rd_fire      = rd_valid & rd_ready;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; an illegal element takes priority over the end-of-matrix edge.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (mm_valid) begin
                    state_nxt = mm_legal ? S_COLLECT : S_ERROR;
                end
            end
            S_COLLECT: begin
                if (bad_elem) begin
                    state_nxt = S_ERROR;
                end else if (busy_fall) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (empty) begin
                    state_nxt = S_IDLE;
                end
            end
            S_ERROR: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Output decode; read data is forced to zero whenever it is not valid.
    always_comb begin
        rd_valid    = (state == S_DRAIN) && !empty;
        mat_done    = ((state == S_DRAIN) && empty) || (state == S_ERROR);
        mat_illegal = (state == S_ERROR);
        rd_data     = '0;
        rd_row      = '0;
        rd_col      = '0;
        rd_last     = 1'b0;
        if (rd_valid) begin
            rd_data = mem_data[rd_ptr[AW-1:0]];
            rd_row  = mem_row[rd_ptr[AW-1:0]];
            rd_col  = mem_col[rd_ptr[AW-1:0]];
            rd_last = (rd_ptr == (wr_ptr - PTR_W'(1)));
        end
    end

    // Pointers, row/column tags, busy history and sticky overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            row_cnt  <= '0;
            col_cnt  <= '0;
            busy_q   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            busy_q <= mm_busy;
            if (drop) begin
                overflow <= 1'b1;
            end
            if (clear_buf) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                row_cnt <= '0;
                col_cnt <= '0;
            end else begin
                if (write_en) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                    if (mm_change_row) begin
                        row_cnt <= row_cnt + IDX_W'(1);
                        col_cnt <= '0;
                    end else begin
                        col_cnt <= col_cnt + IDX_W'(1);
                    end
                end
                if (rd_fire) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
            end
        end
    end

    // Element storage: data plus the tags current at the time of the write.
    always_ff @(posedge clk) begin
        if (write_en) begin
            mem_data[wr_ptr[AW-1:0]] <= mm_data;
            mem_row[wr_ptr[AW-1:0]]  <= row_cnt;
            mem_col[wr_ptr[AW-1:0]]  <= col_cnt;
        end
    end

`ifdef MM_COLLECT_ROWSUM_EN
    localparam int SUM_W = DATA_W + IDX_W;

    logic signed [SUM_W-1:0] row_acc;
    logic signed [SUM_W-1:0] data_ext;

    assign data_ext = {{IDX_W{mm_data[DATA_W-1]}}, mm_data};

    // Per-row accumulation of stored elements; the row-closing element publishes the sum.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_acc       <= '0;
            row_sum       <= '0;
            row_sum_valid <= 1'b0;
        end else begin
            row_sum_valid <= 1'b0;
            if (write_en) begin
                if (mm_change_row) begin
                    row_sum       <= row_acc + data_ext;
                    row_sum_valid <= 1'b1;
                    row_acc       <= '0;
                end else begin
                    row_acc <= row_acc + data_ext;
                end
            end
        end
    end
`endif

endmodule
